// File: rtl/uart_device_if.sv
// Device-bus bundle between the CPU core and the UART register window.
// The core drives the strobe, address and write data; the UART returns registered read data.
interface uart_device_if;
  logic        write_enable;
  logic [15:0] address;
  logic [15:0] data_in;
  logic [15:0] data_out;

  modport master (
    output write_enable,
    output address,
    output data_in,
    input  data_out
  );

  modport slave (
    input  write_enable,
    input  address,
    input  data_in,
    output data_out
  );
endinterface

// File: rtl/uart_device.sv
// Memory-mapped 8N1 UART: STATUS / TX_DATA / RX_DATA / BAUD_DIV word registers, a one-byte
// transmit holding buffer feeding a shift FSM, and a mid-bit sampling receiver with a one-byte buffer.
module uart_device #(
  parameter logic [15:0] BASE_ADDR   = 16'h0010,
  parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
  input  logic          clock,
  input  logic          reset,
  uart_device_if.slave  bus,
  input  logic          rx,
  output logic          tx
);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  logic [15:0] baud_div;

  state_e      tx_state;
  logic [7:0]  tx_hold;
  logic        tx_full;
  logic [7:0]  tx_shift;
  logic [15:0] tx_cnt;
  logic [2:0]  tx_bit;
  logic        tx_load;

  logic        rx_meta;
  logic        rx_sync;
  state_e      rx_state;
  logic [15:0] rx_cnt;
  logic [2:0]  rx_bit;
  logic [7:0]  rx_shift;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic        rx_overrun;
  logic        rx_frame_err;
  logic        rx_stop_done;
  logic        rx_store;
  logic        rx_overrun_set;
  logic        rx_frame_err_set;

  logic        sel;
  logic        wr_status;
  logic        wr_tx;
  logic        wr_pop;
  logic        wr_baud;
  logic [15:0] rd_data;

  assign sel       = (bus.address[15:2] == BASE_ADDR[15:2]);
  assign wr_status = bus.write_enable && sel && (bus.address[1:0] == 2'd0);
  assign wr_tx     = bus.write_enable && sel && (bus.address[1:0] == 2'd1);
  assign wr_pop    = bus.write_enable && sel && (bus.address[1:0] == 2'd2);
  assign wr_baud   = bus.write_enable && sel && (bus.address[1:0] == 2'd3);

  always_comb begin
    rd_data = 16'h0000;
    if (sel) begin
      unique case (bus.address[1:0])
        2'd0: rd_data = {11'h000, rx_frame_err, rx_overrun, rx_valid, tx_full,
                         (tx_state != StIdle)};
        2'd1: rd_data = 16'h0000;
        2'd2: rd_data = {8'h00, rx_byte};
        2'd3: rd_data = baud_div;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      baud_div     <= DEFAULT_DIV;
      bus.data_out <= 16'h0000;
    end else begin
      bus.data_out <= rd_data;
      if (wr_baud) begin
        baud_div <= (bus.data_in < 16'd3) ? 16'd3 : bus.data_in;
      end
    end
  end

  // Holding register hands over either from idle or at the very end of a stop bit.
  assign tx_load = tx_full && ((tx_state == StIdle) || ((tx_state == StStop) && (tx_cnt == 16'd0)));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tx_state <= StIdle;
      tx       <= 1'b1;
      tx_hold  <= 8'h00;
      tx_full  <= 1'b0;
      tx_shift <= 8'h00;
      tx_cnt   <= 16'd0;
      tx_bit   <= 3'd0;
    end else begin
      // A write racing the handover only lands if the buffer was already empty.
      if (tx_load) begin
        tx_full <= 1'b0;
      end else if (wr_tx && !tx_full) begin
        tx_full <= 1'b1;
        tx_hold <= bus.data_in[7:0];
      end
      case (tx_state)
        StIdle: begin
          if (tx_load) begin
            tx_shift <= tx_hold;
            tx       <= 1'b0;
            tx_cnt   <= baud_div;
            tx_state <= StStart;
          end
        end
        StStart: begin
          if (tx_cnt == 16'd0) begin
            tx       <= tx_shift[0];
            tx_shift <= {1'b0, tx_shift[7:1]};
            tx_bit   <= 3'd0;
            tx_cnt   <= baud_div;
            tx_state <= StData;
          end else begin
            tx_cnt <= tx_cnt - 16'd1;
          end
        end
        StData: begin
          if (tx_cnt == 16'd0) begin
            tx_cnt <= baud_div;
            if (tx_bit == 3'd7) begin
              tx       <= 1'b1;
              tx_state <= StStop;
            end else begin
              tx       <= tx_shift[0];
              tx_shift <= {1'b0, tx_shift[7:1]};
              tx_bit   <= tx_bit + 3'd1;
            end
          end else begin
            tx_cnt <= tx_cnt - 16'd1;
          end
        end
        StStop: begin
          if (tx_cnt == 16'd0) begin
            if (tx_load) begin
              tx_shift <= tx_hold;
              tx       <= 1'b0;
              tx_cnt   <= baud_div;
              tx_state <= StStart;
            end else begin
              tx_state <= StIdle;
            end
          end else begin
            tx_cnt <= tx_cnt - 16'd1;
          end
        end
        default: tx_state <= StIdle;
      endcase
    end
  end

  assign rx_stop_done     = (rx_state == StStop) && (rx_cnt == 16'd0);
  assign rx_store         = rx_stop_done && rx_sync && (!rx_valid || wr_pop);
  assign rx_overrun_set   = rx_stop_done && rx_sync && rx_valid && !wr_pop;
  assign rx_frame_err_set = rx_stop_done && !rx_sync;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_meta      <= 1'b1;
      rx_sync      <= 1'b1;
      rx_state     <= StIdle;
      rx_cnt       <= 16'd0;
      rx_bit       <= 3'd0;
      rx_shift     <= 8'h00;
      rx_byte      <= 8'h00;
      rx_valid     <= 1'b0;
      rx_overrun   <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;

      if (rx_store) begin
        rx_valid <= 1'b1;
        rx_byte  <= rx_shift;
      end else if (wr_pop) begin
        rx_valid <= 1'b0;
      end
      if (rx_overrun_set) begin
        rx_overrun <= 1'b1;
      end else if (wr_status && bus.data_in[3]) begin
        rx_overrun <= 1'b0;
      end
      if (rx_frame_err_set) begin
        rx_frame_err <= 1'b1;
      end else if (wr_status && bus.data_in[4]) begin
        rx_frame_err <= 1'b0;
      end

      case (rx_state)
        StIdle: begin
          if (!rx_sync) begin
            // The detecting clock counts toward the half-bit wait.
            rx_cnt   <= {1'b0, baud_div[15:1]} - 16'd1;
            rx_state <= StStart;
          end
        end
        StStart: begin
          if (rx_cnt == 16'd0) begin
            if (rx_sync) begin
              rx_state <= StIdle;
            end else begin
              rx_cnt   <= baud_div;
              rx_bit   <= 3'd0;
              rx_state <= StData;
            end
          end else begin
            rx_cnt <= rx_cnt - 16'd1;
          end
        end
        StData: begin
          if (rx_cnt == 16'd0) begin
            rx_shift <= {rx_sync, rx_shift[7:1]};
            rx_cnt   <= baud_div;
            if (rx_bit == 3'd7) begin
              rx_state <= StStop;
            end else begin
              rx_bit <= rx_bit + 3'd1;
            end
          end else begin
            rx_cnt <= rx_cnt - 16'd1;
          end
        end
        StStop: begin
          if (rx_cnt == 16'd0) begin
            rx_state <= StIdle;
          end else begin
            rx_cnt <= rx_cnt - 16'd1;
          end
        end
        default: rx_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_device.sv
// Randomised bench for uart_device against a frame-level reference model of the UART.
module tb_uart_device;
  logic clock = 1'b0;
  logic reset;
  logic rx_drv;
  logic loop;
  logic rx_pin;
  logic tx;

  uart_device_if bus ();

  assign rx_pin = loop ? tx : rx_drv;

  uart_device #(
    .BASE_ADDR   (16'h0010),
    .DEFAULT_DIV (16'd433)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus),
    .rx    (rx_pin),
    .tx    (tx)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  // Reference model: receive buffer and flags as seen by software, plus the divider.
  int         m_div;
  logic       m_valid;
  logic       m_overrun;
  logic       m_ferr;
  logic [7:0] m_byte;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model_status(input logic busy, input logic full);
    return {11'h000, m_ferr, m_overrun, m_valid, full, busy};
  endfunction

  task automatic model_reset();
    m_div     = 433;
    m_valid   = 1'b0;
    m_overrun = 1'b0;
    m_ferr    = 1'b0;
    m_byte    = 8'h00;
  endtask

  // A complete received frame: framing error, overrun, or a new byte.
  task automatic model_frame(input logic [7:0] b, input logic stop);
    if (!stop) m_ferr = 1'b1;
    else if (m_valid) m_overrun = 1'b1;
    else begin
      m_valid = 1'b1;
      m_byte  = b;
    end
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
    @(negedge clock);
    bus.write_enable = 1'b1;
    bus.address      = a;
    bus.data_in      = d;
    @(negedge clock);
    bus.write_enable = 1'b0;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [15:0] d);
    @(negedge clock);
    bus.write_enable = 1'b0;
    bus.address      = a;
    @(posedge clock);
    #1 d = bus.data_out;
  endtask

  task automatic set_div(input int d);
    bus_write(16'h0013, d[15:0]);
    m_div = (d < 3) ? 3 : d;
  endtask

  // Sends b0 (and b1 while busy, then b2 while the buffer is full) and checks tx every clock.
  task automatic tx_run(input string tag, input logic [7:0] b0, input bit two,
                        input logic [7:0] b1, input logic [7:0] b2);
    logic        exp_q[$];
    logic [9:0]  fr;
    logic [15:0] st;
    bit          bad = 0;
    for (int f = 0; f < (two ? 2 : 1); f++) begin
      fr = {1'b1, (f == 0) ? b0 : b1, 1'b0};
      for (int k = 0; k < 10; k++) repeat (m_div + 1) exp_q.push_back(fr[k]);
    end
    repeat (2 * (m_div + 1)) exp_q.push_back(1'b1);
    @(negedge clock);
    bus.write_enable = 1'b1;
    bus.address      = 16'h0011;
    bus.data_in      = {8'h00, b0};
    @(posedge clock);
    #1 check_eq({tag, "_idle_at_write"}, {15'h0, tx}, 16'h0001);
    @(negedge clock);
    bus.write_enable = 1'b0;
    bus.address      = 16'h0010;
    for (int j = 0; j < exp_q.size(); j++) begin
      @(posedge clock);
      #1;
      if (!bad) begin
        bad = (tx !== exp_q[j]);
        check_eq($sformatf("%s_bit_cycle%0d", tag, j), {15'h0, tx}, {15'h0, exp_q[j]});
      end
      if (j == 1) check_eq({tag, "_status_after_load"}, bus.data_out, model_status(1'b1, 1'b0));
      if (two && j == 3) begin
        bus.write_enable = 1'b1;
        bus.address      = 16'h0011;
        bus.data_in      = {8'h00, b1};
      end
      if (two && j == 8) begin
        bus.write_enable = 1'b1;
        bus.address      = 16'h0011;
        bus.data_in      = {8'h00, b2};
      end
      if (two && (j == 4 || j == 9)) begin
        bus.write_enable = 1'b0;
        bus.address      = 16'h0010;
      end
    end
    bus_read(16'h0010, st);
    check_eq({tag, "_status_done"}, st, model_status(1'b0, 1'b0));
  endtask

  task automatic drive_frame(input logic [7:0] b, input logic stop);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    @(negedge clock);
    for (int k = 0; k < 9; k++) begin
      rx_drv = fr[k];
      repeat (m_div + 1) @(negedge clock);
    end
    rx_drv = stop;
    // A low stop bit is cut short: seen low at mid-bit, released before it can pass as a start.
    if (stop) repeat (m_div + 1) @(negedge clock);
    else repeat ((m_div >> 1) + 1 + (m_div >> 2)) @(negedge clock);
    rx_drv = 1'b1;
    repeat (4) @(negedge clock);
    model_frame(b, stop);
  endtask

  task automatic loopback(input string tag, input logic [7:0] b);
    logic [15:0] st;
    int          n = 0;
    bus_write(16'h0011, {8'h00, b});
    do begin
      bus_read(16'h0010, st);
      n++;
    end while (!st[2] && n < 400);
    check_eq({tag, "_valid_seen"}, {15'h0, st[2]}, 16'h0001);
    model_frame(b, 1'b1);
    bus_read(16'h0012, st);
    check_eq({tag, "_rx_data"}, st, {8'h00, m_byte});
    repeat (3 * (m_div + 1)) @(negedge clock);
    bus_read(16'h0010, st);
    check_eq({tag, "_status_held"}, st, model_status(1'b0, 1'b0));
    bus_write(16'h0012, 16'($urandom));
    m_valid = 1'b0;
    bus_read(16'h0010, st);
    check_eq({tag, "_status_popped"}, st, model_status(1'b0, 1'b0));
  endtask

  initial begin
    logic [15:0] st;
    logic [7:0]  rb;
    int          d;
    bus.write_enable = 1'b0;
    bus.address      = 16'h0000;
    bus.data_in      = 16'h0000;
    rx_drv = 1'b1;
    loop   = 1'b0;
    reset  = 1'b1;
    model_reset();
    #1;
    check_eq("reset_tx", {15'h0, tx}, 16'h0001);
    check_eq("reset_data_out", bus.data_out, 16'h0000);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    bus_read(16'h0010, st);
    check_eq("reset_status", st, model_status(1'b0, 1'b0));
    bus_read(16'h0013, st);
    check_eq("reset_baud", st, 16'(m_div));
    bus_read(16'h0012, st);
    check_eq("reset_rx_byte", st, 16'h0000);

    set_div(1);
    bus_read(16'h0013, st);
    check_eq("baud_clamp1", st, 16'(m_div));
    set_div(2);
    bus_read(16'h0013, st);
    check_eq("baud_clamp2", st, 16'(m_div));
    set_div(7);
    bus_read(16'h0013, st);
    check_eq("baud_7", st, 16'd7);

    tx_run("tx_a5", 8'hA5, 1'b0, 8'h00, 8'h00);
    tx_run("tx_b2b", 8'h55, 1'b1, 8'h0F, 8'($urandom));
    for (int i = 0; i < 3; i++) begin
      set_div($urandom_range(3, 9));
      tx_run($sformatf("tx_rand%0d", i), 8'($urandom), 1'($urandom), 8'($urandom), 8'($urandom));
    end

    set_div(7);
    loop = 1'b1;
    loopback("lb_3c", 8'h3C);
    for (int i = 0; i < 2; i++) loopback($sformatf("lb_rand%0d", i), 8'($urandom));
    loop = 1'b0;

    rb = 8'($urandom);
    drive_frame(rb, 1'b1);
    drive_frame(8'($urandom), 1'b1);
    bus_read(16'h0010, st);
    check_eq("ovr_status", st, model_status(1'b0, 1'b0));
    bus_read(16'h0012, st);
    check_eq("ovr_first_kept", st, {8'h00, rb});
    drive_frame(8'($urandom), 1'b0);
    bus_read(16'h0010, st);
    check_eq("ferr_status", st, model_status(1'b0, 1'b0));
    bus_read(16'h0012, st);
    check_eq("ferr_byte_kept", st, {8'h00, m_byte});
    bus_write(16'h0010, 16'h0018);
    m_overrun = 1'b0;
    m_ferr    = 1'b0;
    bus_read(16'h0010, st);
    check_eq("w1c_status", st, model_status(1'b0, 1'b0));
    bus_write(16'h0012, 16'h0000);
    m_valid = 1'b0;
    bus_read(16'h0010, st);
    check_eq("pop_status", st, model_status(1'b0, 1'b0));

    d = $urandom_range(3, 12);
    set_div(d);
    for (int i = 0; i < 3; i++) begin
      drive_frame(8'($urandom), 1'b1);
      bus_read(16'h0012, st);
      check_eq($sformatf("rx_rand%0d_data", i), st, {8'h00, m_byte});
      bus_read(16'h0010, st);
      check_eq($sformatf("rx_rand%0d_status", i), st, model_status(1'b0, 1'b0));
      bus_write(16'h0012, 16'h0000);
      m_valid = 1'b0;
    end

    set_div(7);
    @(negedge clock);
    rx_drv = 1'b0;
    repeat (2) @(negedge clock);
    rx_drv = 1'b1;
    repeat (30) @(negedge clock);
    bus_read(16'h0010, st);
    check_eq("glitch_status", st, model_status(1'b0, 1'b0));
    bus_read(16'h0014, st);
    check_eq("decode_0x14", st, 16'h0000);
    bus_read(16'h0017, st);
    check_eq("decode_0x17", st, 16'h0000);
    bus_read(16'h0011, st);
    check_eq("tx_data_reads0", st, 16'h0000);
    bus_write(16'h0015, 16'h00AA);
    repeat (2) @(negedge clock);
    bus_read(16'h0010, st);
    check_eq("unselected_write", st, model_status(1'b0, 1'b0));

    bus_write(16'h0011, 16'h0000);
    @(posedge clock);
    #1 check_eq("midframe_tx_low", {15'h0, tx}, 16'h0000);
    #2 reset = 1'b1;
    #1 check_eq("midframe_reset_tx", {15'h0, tx}, 16'h0001);
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    bus_read(16'h0010, st);
    check_eq("midframe_reset_status", st, model_status(1'b0, 1'b0));
    bus_read(16'h0013, st);
    check_eq("midframe_reset_baud", st, 16'(m_div));
    repeat (20) @(negedge clock);
    check_eq("midframe_tx_stays_idle", {15'h0, tx}, 16'h0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
